// File: rtl/cond_pkg.sv
// Shared types and constants for the condition unit (cond_unit, cond_check).
package cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_CS = 4'h2,
      COND_CC = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'hA,
      COND_LT = 4'hB,
      COND_GT = 4'hC,
      COND_LE = 4'hD,
      COND_AL = 4'hE,
      COND_NV = 4'hF
   } cond_e;

   localparam int FLAG_N       = 3;
   localparam int FLAG_Z       = 2;
   localparam int FLAG_C       = 1;
   localparam int FLAG_V       = 0;
   localparam int FLAGW_NZ     = 1;
   localparam int FLAGW_CV     = 0;
   localparam int SQUASH_CNT_W = 16;

endpackage

// File: rtl/cond_check.sv
// Purely combinational evaluation of a 4-bit condition code against NZCV.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b1;
      case (cond_e'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c & !z;
         COND_LS: pass = !c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z & (n == v);
         COND_LE: pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: gates decoder strobes, holds NZCV and counts squashed instructions.
// Optional COND_FLAG_BYPASS_EN forwards same-cycle alu_flags into the evaluation.
module cond_unit
   import cond_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              alu_flags,
   input  logic [3:0]              cond,
   input  logic [1:0]              flag_w,
   input  logic                    instr_valid,
   input  logic                    reg_w_in,
   input  logic                    mem_w_in,
   input  logic                    pc_s_in,
   output logic                    reg_w_out,
   output logic                    mem_w_out,
   output logic                    pc_s_out,
   output logic                    cond_ex,
   output logic [3:0]              flags_q,
   output logic [SQUASH_CNT_W-1:0] squash_cnt
);

   logic [3:0]              flags_d;
   logic [SQUASH_CNT_W-1:0] squash_cnt_d, squash_cnt_q;
   logic [3:0]              eval_flags;
   logic                    pass;

`ifdef COND_FLAG_BYPASS_EN
   // Forward each field pair the current instruction is writing.
   always_comb begin
      eval_flags = flags_q;
      if (instr_valid && flag_w[FLAGW_NZ])
         eval_flags[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
      if (instr_valid && flag_w[FLAGW_CV])
         eval_flags[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
   end
`else
   assign eval_flags = flags_q;
`endif

   cond_check u_cond_check (
      .cond (cond),
      .nzcv (eval_flags),
      .pass (pass)
   );

   assign cond_ex   = instr_valid & pass;
   assign reg_w_out = reg_w_in & cond_ex;
   assign mem_w_out = mem_w_in & cond_ex;
   assign pc_s_out  = pc_s_in  & cond_ex;

   always_comb begin
      flags_d = flags_q;
      if (cond_ex && flag_w[FLAGW_NZ])
         flags_d[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
      if (cond_ex && flag_w[FLAGW_CV])
         flags_d[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
   end

   // Saturating count of real instructions whose condition failed.
   always_comb begin
      squash_cnt_d = squash_cnt_q;
      if (instr_valid && !pass && (squash_cnt_q != {SQUASH_CNT_W{1'b1}}))
         squash_cnt_d = squash_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q      <= 4'b0000;
         squash_cnt_q <= '0;
      end else begin
         flags_q      <= flags_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign squash_cnt = squash_cnt_q;

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 cond_unit SHALL have exactly one clock and one reset: clk input 1, rising-edge clock; rst input 1, asynchronous, active-high reset.
REQ-002 alu_flags  input 4: ALU flags {N,Z,C,V}, with bit 3 = N and bit 0 = V.
REQ-003 cond  input 4: condition field of the current instruction.
REQ-004 flag_w  input 2: flag write request; bit 1 updates N,Z; bit 0 updates C,V.
REQ-005 instr_valid  input 1: the current-cycle instruction is real; when low it is a bubble.
REQ-006 reg_w_in, mem_w_in, pc_s_in  input 1 each: unconditioned control strobes from the decoder.
REQ-007 reg_w_out, mem_w_out, pc_s_out  output 1 each: strobes gated by the condition result.
REQ-008 cond_ex  output 1: the condition passed and instr_valid is high.
REQ-009 flags_q  output 4: registered NZCV.
REQ-010 squash_cnt  output 16: count of valid instructions whose condition failed.

Function
REQ-011 The evaluation source SHALL be:
- flags_q in the base build;
- the bypass rule of REQ-023 when COND_FLAG_BYPASS_EN is defined.
REQ-012 Condition results SHALL be:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C&!Z
- 1001 LS: !C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 1
REQ-013 cond_ex = instr_valid & pass, combinational, with zero latency.
REQ-014 Each gated strobe (reg_w_out, mem_w_out, pc_s_out) SHALL equal its _in input AND cond_ex.
REQ-015 On a rising clk edge with cond_ex=1 and flag_w[1]=1, flags_q[3:2] SHALL load alu_flags[3:2].
REQ-016 On a rising clk edge with cond_ex=1 and flag_w[0]=1, flags_q[1:0] SHALL load alu_flags[1:0].
REQ-017 Flag fields not selected, and all fields when cond_ex=0, SHALL hold their value; a squashed or bubble instruction never updates flags.
REQ-018 squash_cnt SHALL increment by 1 at a clock edge where instr_valid=1 and pass=0.
REQ-019 squash_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-020 A bubble (instr_valid=0) SHALL NOT change squash_cnt or the flags, regardless of cond and flag_w.

Reset
REQ-021 While rst=1, asynchronously and independent of clk: flags_q=4'b0000 and squash_cnt=0.
REQ-022 While rst=1, all outputs SHALL be driven from those reset values, with no X; a flag write in progress when rst asserts is discarded.

Configuration
REQ-023 With COND_FLAG_BYPASS_EN defined, evaluation SHALL use, per field pair:
- alu_flags where the matching flag_w bit is 1 and instr_valid=1 (same-cycle forwarding);
- flags_q otherwise.
REQ-024 Without COND_FLAG_BYPASS_EN, evaluation SHALL use only flags_q, and alu_flags SHALL affect nothing but the next-state flags.

Structure
REQ-025 A shared package cond_pkg SHALL hold:
- the cond_e enum (16 codes);
- flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
- FLAGW_NZ=1 and FLAGW_CV=0;
- SQUASH_CNT_W=16.
REQ-026 Condition evaluation SHALL live in one combinational sub-module, cond_check (inputs cond and nzcv; output pass), instantiated once.

Verification
REQ-027 Reset: assert rst mid-cycle with flags_q=1111 and squash_cnt=5 -> both read 0 immediately, before the next clk edge.
REQ-028 Flag update, base build:
- flags_q=0000, cond=AL, flag_w=11, alu_flags=0110, valid=1 -> flags_q=0110 after the edge;
- then cond=EQ -> cond_ex=1;
- cond=NE -> cond_ex=0.
REQ-029 Partial write: flags_q=1111, flag_w=10, alu_flags=0000, cond=AL -> flags_q=0011.
REQ-030 Squash:
- flags_q=0000, cond=EQ, reg_w_in=1, flag_w=11, alu_flags=1111 -> reg_w_out=0, flags_q stays 0000, squash_cnt +1;
- the same stimulus with valid=0 -> squash_cnt unchanged.
REQ-031 Saturation: preload via 65535 failing instructions -> squash_cnt=FFFF; one more failing instruction -> FFFF.
REQ-032 Bypass build: flags_q=0000, cond=EQ, flag_w=10, alu_flags=0100, valid=1 -> cond_ex=1 in the same cycle; the base build gives cond_ex=0. The bench SHALL also sweep all 16 cond values × 16 NZCV values against REQ-012.
